mem_arbiter: RTL

Two-port arbiter that shares one single-port synchronous unified memory between the CPU's instruction-fetch port and its load/store data port. It sits between `cpu` (PC/fetch path and `Memorytop` data path) and the memory array. It grants one access per cycle with round-robin fairness, tracks the single outstanding transaction, and returns a one-cycle-later acknowledge with read data. It also drives `stall_f` so the PC register holds while a fetch waits.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/mem_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default sizes for the instruction/data memory arbiter.
//   PORT_F / PORT_D : port identifiers (fetch = 0, data = 1)
//   port_t          : one-bit port selector type
//   DEFAULT_AW      : default memory address width (matches PC[27:0])
//   DEFAULT_WIDTH   : default data word width
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef logic port_t;

    localparam port_t PORT_F = 1'b0;
    localparam port_t PORT_D = 1'b1;

    localparam int DEFAULT_AW    = 28;
    localparam int DEFAULT_WIDTH = 32;

    // The port that should win the next tie after `p` has been served.
    function automatic port_t other_port(input port_t p);
        return ~p;
    endfunction

endpackage : mem_arb_pkg

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-way priority picker used by mem_arbiter.
//   req[1:0] in  : eligible requests (bit 0 = fetch, bit 1 = data)
//   prio     in  : port that wins when both requests are present
//   gnt[1:0] out : one-hot grant, or zero when nothing is requested
//   gnt_idx  out : index of the granted port (PORT_F when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic  [1:0] req,
    input  port_t       prio,
    output logic  [1:0] gnt,
    output port_t       gnt_idx
);

    // A port wins if it requests and either the other port is idle or the
    // tie-break points at it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = req[gi] & (~req[1-gi] | (prio == port_t'(gi)));
        end
    endgenerate

    assign gnt_idx = gnt[1] ? PORT_D : PORT_F;

endmodule : rr_arbiter2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous memory between the CPU instruction fetch
// port and the load/store data port. One access is granted per cycle with
// round-robin tie-breaking; the single outstanding access is acknowledged one
// cycle after its grant, when the memory read data arrives.
//
// Ports
//   CLK, rst                      clock; synchronous active-high reset
//   f_req, f_addr                 fetch request (held until f_ack) / address
//   d_req, d_we, d_addr, d_wdata  data request (held until d_ack)
//   f_ack, d_ack                  completion strobes (registered)
//   rdata                         read data, straight from mem_rdata
//   stall_f                       holds the PC while a fetch is waiting
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata          memory side, rdata 1 cycle after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = DEFAULT_AW
)(
    input  logic             CLK,
    input  logic             rst,
    input  logic             f_req,
    input  logic [AW-1:0]    f_addr,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             f_ack,
    output logic             d_ack,
    output logic [WIDTH-1:0] rdata,
    output logic             stall_f,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    logic  r_busy;
    port_t r_owner;
    port_t r_prio;

    logic [1:0] w_raw_req;
    logic [1:0] w_mask;
    logic [1:0] w_elig;
    logic [1:0] w_gnt;
    port_t      w_gnt_idx;
    logic       w_any_gnt;

    assign w_raw_req = {d_req, f_req};

    // The owner still holds its request during its ack cycle; masking it
    // stops that stale request from being granted a second time.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mask
            assign w_mask[gi] = r_busy & (r_owner == port_t'(gi));
        end
    endgenerate

    // Nothing is eligible while reset is held, so the memory side stays idle.
    assign w_elig = w_raw_req & ~w_mask & {2{~rst}};

    rr_arbiter2 u_rr_arbiter2 (
        .req     (w_elig),
        .prio    (r_prio),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_any_gnt = |w_gnt;

    // Memory request mux: fetch is always a read with zero write data.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt[PORT_F]) begin
            mem_en   = 1'b1;
            mem_addr = f_addr;
        end else if (w_gnt[PORT_D]) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_owner <= PORT_F;
            r_prio  <= PORT_F;
        end else if (w_any_gnt) begin
            r_busy  <= 1'b1;
            r_owner <= w_gnt_idx;
            r_prio  <= other_port(w_gnt_idx);
        end else begin
            r_busy  <= 1'b0;
        end
    end

    // Acks come from registered state; gating with rst drops an access that
    // was in flight when reset arrived.
    assign f_ack   = r_busy & ~rst & (r_owner == PORT_F);
    assign d_ack   = r_busy & ~rst & (r_owner == PORT_D);
    assign rdata   = mem_rdata;
    assign stall_f = f_req & ~f_ack;

endmodule : mem_arbiter
